directory_controller: RTL and testbench



---
 rtl/dir_pkg.sv | 42 ++++
 rtl/dir_storage.sv | 47 ++++
 rtl/directory_controller.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_directory_controller.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dir_pkg.sv
// Shared encodings for the MSI home-node directory: entry states, request and
// message types, the controller FSM states and a small popcount helper.
package dir_pkg;

    typedef enum logic [1:0] {
        DIR_UNCACHED = 2'b01,
        DIR_SHARED   = 2'b10,
        DIR_MODIFIED = 2'b11
    } dirState_t;

    typedef enum logic [1:0] {
        REQ_WRITE_BACK = 2'b00,
        REQ_READ_MISS  = 2'b01,
        REQ_WRITE_MISS = 2'b10,
        REQ_INVALIDATE = 2'b11
    } reqType_t;

    typedef enum logic [1:0] {
        MSG_NONE             = 2'b00,
        MSG_INVALIDATE       = 2'b01,
        MSG_FETCH            = 2'b10,
        MSG_FETCH_INVALIDATE = 2'b11
    } msgType_t;

    typedef enum logic [2:0] {
        FSM_IDLE,
        FSM_LOOKUP,
        FSM_SEND,
        FSM_WAIT_ACK,
        FSM_REPLY
    } fsmState_t;

    function automatic logic [4:0] popCount16(input logic [15:0] v);
        logic [4:0] count;
        count = '0;
        for (int i = 0; i < 16; i++) begin
            count = count + 5'(v[i]);
        end
        return count;
    endfunction

endpackage

// File: rtl/dir_storage.sv
// Directory entry store: one {state, sharers} register per block, one
// combinational read port, one write port, cleared to UNCACHED on reset.
module dir_storage
    import dir_pkg::*;
#(
    parameter int NUM_NODES  = 4,
    parameter int NUM_BLOCKS = 16,
    parameter int ADDR_W     = $clog2(NUM_BLOCKS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    rdAddr,
    output logic [1:0]           rdState,
    output logic [NUM_NODES-1:0] rdSharers,
    input  logic                 wrEn,
    input  logic [ADDR_W-1:0]    wrAddr,
    input  logic [1:0]           wrState,
    input  logic [NUM_NODES-1:0] wrSharers
);

    logic [1:0]           stateArr   [NUM_BLOCKS];
    logic [NUM_NODES-1:0] sharersArr [NUM_BLOCKS];

    generate
        for (genvar gi = 0; gi < NUM_BLOCKS; gi++) begin : gEntry
            logic [1:0]           stateReg;
            logic [NUM_NODES-1:0] sharersReg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    stateReg   <= DIR_UNCACHED;
                    sharersReg <= '0;
                end else if (wrEn && (wrAddr == ADDR_W'(gi))) begin
                    stateReg   <= wrState;
                    sharersReg <= wrSharers;
                end
            end

            assign stateArr[gi]   = stateReg;
            assign sharersArr[gi] = sharersReg;
        end
    endgenerate

    assign rdState   = stateArr[rdAddr];
    assign rdSharers = sharersArr[rdAddr];

endmodule

// File: rtl/directory_controller.sv
// MSI home-node directory controller: one request at a time, sends
// invalidate/fetch messages, collects acks, replies with the granted state.
// Optional statistic counters are built when DIR_STATS_EN is defined.
module directory_controller
    import dir_pkg::*;
#(
    parameter int NUM_NODES  = 4,
    parameter int NUM_BLOCKS = 16,
    parameter int STAT_W     = 16,
    parameter int NODE_W     = $clog2(NUM_NODES),
    parameter int ADDR_W     = $clog2(NUM_BLOCKS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [NODE_W-1:0]    req_node,
    input  logic [1:0]           req_type,
    input  logic [ADDR_W-1:0]    req_addr,
    output logic                 msg_valid,
    input  logic                 msg_ready,
    output logic [1:0]           msg_type,
    output logic [NUM_NODES-1:0] msg_dest,
    output logic [ADDR_W-1:0]    msg_addr,
    input  logic                 ack_valid,
    input  logic [NODE_W-1:0]    ack_node,
    output logic                 mem_wb,
    output logic                 reply_valid,
    output logic [NODE_W-1:0]    reply_node,
    output logic [1:0]           reply_state,
    output logic [STAT_W-1:0]    stat_inval,
    output logic [STAT_W-1:0]    stat_fetch
);

    fsmState_t stateReg, stateNext;

    logic [NODE_W-1:0]    nodeReg;
    logic [1:0]           typeReg;
    logic [ADDR_W-1:0]    addrReg;
    logic [1:0]           msgTypeReg;
    logic [NUM_NODES-1:0] msgDestReg;
    logic [ADDR_W-1:0]    msgAddrReg;
    logic [NUM_NODES-1:0] pendingReg;
    logic [1:0]           finalStateReg;
    logic [NUM_NODES-1:0] finalSharersReg;
    logic                 msgCaseReg;
    logic                 fetchReg;
    logic                 replyEnReg;
    logic [NODE_W-1:0]    replyNodeReg;
    logic [1:0]           replyStateReg;
    logic                 memWbReg;

    logic [1:0]           curState;
    logic [NUM_NODES-1:0] curSharers;
    logic                 wrEn;
    logic [1:0]           wrState;
    logic [NUM_NODES-1:0] wrSharers;

    dir_storage #(
        .NUM_NODES (NUM_NODES),
        .NUM_BLOCKS(NUM_BLOCKS),
        .ADDR_W    (ADDR_W)
    ) uStorage (
        .clk      (clk),
        .reset    (reset),
        .rdAddr   (addrReg),
        .rdState  (curState),
        .rdSharers(curSharers),
        .wrEn     (wrEn),
        .wrAddr   (addrReg),
        .wrState  (wrState),
        .wrSharers(wrSharers)
    );

    // Lookup decision: what the captured request does to the current entry.
    logic [NUM_NODES-1:0] reqMask;
    logic                 isRead;
    logic                 isMiss;
    logic                 luNeedMsg;
    logic [1:0]           luMsgType;
    logic [NUM_NODES-1:0] luDest;
    logic [1:0]           luState;
    logic [NUM_NODES-1:0] luSharers;
    logic                 luReplyEn;
    logic [1:0]           luReplyState;
    logic                 luWb;
    logic                 luFetch;

    always_comb begin
        reqMask      = NUM_NODES'(1) << nodeReg;
        isRead       = (typeReg == REQ_READ_MISS);
        isMiss       = (typeReg != REQ_WRITE_BACK);
        luNeedMsg    = 1'b0;
        luMsgType    = MSG_NONE;
        luDest       = '0;
        luState      = curState;
        luSharers    = curSharers;
        luReplyEn    = 1'b0;
        luReplyState = DIR_SHARED;
        luWb         = 1'b0;
        luFetch      = 1'b0;
        case (curState)
            DIR_SHARED: begin
                if (isRead) begin
                    luSharers    = curSharers | reqMask;
                    luReplyEn    = 1'b1;
                    luReplyState = DIR_SHARED;
                end else if (isMiss) begin
                    luDest       = curSharers & ~reqMask;
                    luNeedMsg    = |luDest;
                    luMsgType    = MSG_INVALIDATE;
                    luState      = DIR_MODIFIED;
                    luSharers    = reqMask;
                    luReplyEn    = 1'b1;
                    luReplyState = DIR_MODIFIED;
                end
            end
            DIR_MODIFIED: begin
                if (curSharers == reqMask) begin
                    if (isMiss) begin
                        luReplyEn    = 1'b1;
                        luReplyState = DIR_MODIFIED;
                    end else begin
                        luWb      = 1'b1;
                        luState   = DIR_UNCACHED;
                        luSharers = '0;
                    end
                end else if (isMiss) begin
                    // The owner's copy must come home before anyone else is granted.
                    luNeedMsg = 1'b1;
                    luFetch   = 1'b1;
                    luDest    = curSharers;
                    luReplyEn = 1'b1;
                    if (isRead) begin
                        luMsgType    = MSG_FETCH;
                        luState      = DIR_SHARED;
                        luSharers    = curSharers | reqMask;
                        luReplyState = DIR_SHARED;
                    end else begin
                        luMsgType    = MSG_FETCH_INVALIDATE;
                        luState      = DIR_MODIFIED;
                        luSharers    = reqMask;
                        luReplyState = DIR_MODIFIED;
                    end
                end
            end
            default: begin
                if (isMiss) begin
                    luState      = isRead ? DIR_SHARED : DIR_MODIFIED;
                    luSharers    = reqMask;
                    luReplyEn    = 1'b1;
                    luReplyState = isRead ? DIR_SHARED : DIR_MODIFIED;
                end
            end
        endcase
    end

    logic [NUM_NODES-1:0] ackMask;
    logic [NUM_NODES-1:0] pendingAfter;

    always_comb begin
        ackMask      = ack_valid ? (NUM_NODES'(1) << ack_node) : '0;
        pendingAfter = pendingReg & ~ackMask;
        stateNext    = stateReg;
        case (stateReg)
            FSM_IDLE:     if (req_valid) stateNext = FSM_LOOKUP;
            FSM_LOOKUP:   stateNext = luNeedMsg ? FSM_SEND : FSM_REPLY;
            FSM_SEND:     if (msg_ready) stateNext = FSM_WAIT_ACK;
            FSM_WAIT_ACK: if (pendingAfter == '0) stateNext = FSM_REPLY;
            FSM_REPLY:    stateNext = FSM_IDLE;
            default:      stateNext = FSM_IDLE;
        endcase
    end

    // Entry commits at LOOKUP when no message is needed, otherwise after the acks.
    assign wrEn      = ((stateReg == FSM_LOOKUP) && !luNeedMsg) ||
                       ((stateReg == FSM_REPLY) && msgCaseReg);
    assign wrState   = (stateReg == FSM_LOOKUP) ? luState : finalStateReg;
    assign wrSharers = (stateReg == FSM_LOOKUP) ? luSharers : finalSharersReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg        <= FSM_IDLE;
            nodeReg         <= '0;
            typeReg         <= '0;
            addrReg         <= '0;
            msgTypeReg      <= '0;
            msgDestReg      <= '0;
            msgAddrReg      <= '0;
            pendingReg      <= '0;
            finalStateReg   <= '0;
            finalSharersReg <= '0;
            msgCaseReg      <= 1'b0;
            fetchReg        <= 1'b0;
            replyEnReg      <= 1'b0;
            replyNodeReg    <= '0;
            replyStateReg   <= '0;
            memWbReg        <= 1'b0;
        end else begin
            stateReg <= stateNext;
            memWbReg <= ((stateReg == FSM_LOOKUP) && luWb) ||
                        ((stateReg == FSM_REPLY) && msgCaseReg && fetchReg);
            if ((stateReg == FSM_IDLE) && req_valid) begin
                nodeReg <= req_node;
                typeReg <= req_type;
                addrReg <= req_addr;
            end
            if (stateReg == FSM_LOOKUP) begin
                finalStateReg   <= luState;
                finalSharersReg <= luSharers;
                msgCaseReg      <= luNeedMsg;
                fetchReg        <= luFetch;
                replyEnReg      <= luReplyEn;
                if (luNeedMsg) begin
                    msgTypeReg <= luMsgType;
                    msgDestReg <= luDest;
                    msgAddrReg <= addrReg;
                end
                if (luReplyEn) begin
                    replyNodeReg  <= nodeReg;
                    replyStateReg <= luReplyState;
                end
            end
            if ((stateReg == FSM_SEND) && msg_ready) begin
                pendingReg <= msgDestReg;
            end
            if (stateReg == FSM_WAIT_ACK) begin
                pendingReg <= pendingAfter;
            end
        end
    end

    assign req_ready   = (stateReg == FSM_IDLE);
    assign msg_valid   = (stateReg == FSM_SEND);
    assign msg_type    = msgTypeReg;
    assign msg_dest    = msgDestReg;
    assign msg_addr    = msgAddrReg;
    assign mem_wb      = memWbReg;
    assign reply_valid = (stateReg == FSM_REPLY) && replyEnReg;
    assign reply_node  = replyNodeReg;
    assign reply_state = replyStateReg;

`ifdef DIR_STATS_EN
    localparam int SUM_W = STAT_W + 1;

    logic [STAT_W-1:0] statInvalReg;
    logic [STAT_W-1:0] statFetchReg;
    logic              msgAccept;
    logic [4:0]        destCount;
    logic [SUM_W-1:0]  invalSum;
    logic [SUM_W-1:0]  fetchSum;

    always_comb begin
        msgAccept = (stateReg == FSM_SEND) && msg_ready;
        destCount = popCount16(16'(msgDestReg));
        invalSum  = {1'b0, statInvalReg} + SUM_W'(destCount);
        fetchSum  = {1'b0, statFetchReg} + SUM_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            statInvalReg <= '0;
            statFetchReg <= '0;
        end else if (msgAccept) begin
            if ((msgTypeReg == MSG_INVALIDATE) || (msgTypeReg == MSG_FETCH_INVALIDATE)) begin
                statInvalReg <= invalSum[STAT_W] ? '1 : invalSum[STAT_W-1:0];
            end
            if ((msgTypeReg == MSG_FETCH) || (msgTypeReg == MSG_FETCH_INVALIDATE)) begin
                statFetchReg <= fetchSum[STAT_W] ? '1 : fetchSum[STAT_W-1:0];
            end
        end
    end

    assign stat_inval = statInvalReg;
    assign stat_fetch = statFetchReg;
`else
    assign stat_inval = '0;
    assign stat_fetch = '0;
`endif

endmodule

// File: tb/tb_directory_controller.sv
// Self-checking bench for directory_controller: directed scenarios plus
// randomized requests and ack orders against a rule-level directory model.
module tb_directory_controller;

    localparam int NN = 4;
    localparam int NB = 16;
    localparam int SW = 16;
    localparam int NW = 2;
    localparam int AW = 4;

    localparam logic [1:0] UNC = 2'b01, SHR = 2'b10, MOD = 2'b11;
    localparam logic [1:0] WB = 2'b00, RM = 2'b01, WM = 2'b10, INV = 2'b11;
    localparam logic [1:0] M_INV = 2'b01, M_FETCH = 2'b10, M_FINV = 2'b11;

`ifdef DIR_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [NW-1:0] req_node;
    logic [1:0]    req_type;
    logic [AW-1:0] req_addr;
    logic          msg_valid;
    logic          msg_ready;
    logic [1:0]    msg_type;
    logic [NN-1:0] msg_dest;
    logic [AW-1:0] msg_addr;
    logic          ack_valid;
    logic [NW-1:0] ack_node;
    logic          mem_wb;
    logic          reply_valid;
    logic [NW-1:0] reply_node;
    logic [1:0]    reply_state;
    logic [SW-1:0] stat_inval;
    logic [SW-1:0] stat_fetch;

    directory_controller dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_node   (req_node),
        .req_type   (req_type),
        .req_addr   (req_addr),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_type   (msg_type),
        .msg_dest   (msg_dest),
        .msg_addr   (msg_addr),
        .ack_valid  (ack_valid),
        .ack_node   (ack_node),
        .mem_wb     (mem_wb),
        .reply_valid(reply_valid),
        .reply_node (reply_node),
        .reply_state(reply_state),
        .stat_inval (stat_inval),
        .stat_fetch (stat_fetch)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [1:0]    mState   [NB];
    logic [NN-1:0] mSharers [NB];
    int            modelInval;
    int            modelFetch;
    int            ackScript[$];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int b = 0; b < NB; b++) begin
            mState[b]   = UNC;
            mSharers[b] = '0;
        end
        modelInval = 0;
        modelFetch = 0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_req_ready"},   req_ready,   1);
        checkVal({tag, "_msg_valid"},   msg_valid,   0);
        checkVal({tag, "_reply_valid"}, reply_valid, 0);
        checkVal({tag, "_mem_wb"},      mem_wb,      0);
        checkVal({tag, "_msg_type"},    msg_type,    0);
        checkVal({tag, "_msg_dest"},    msg_dest,    0);
        checkVal({tag, "_msg_addr"},    msg_addr,    0);
        checkVal({tag, "_reply_node"},  reply_node,  0);
        checkVal({tag, "_reply_state"}, reply_state, 0);
        checkVal({tag, "_stat_inval"},  stat_inval,  0);
        checkVal({tag, "_stat_fetch"},  stat_fetch,  0);
    endtask

    task automatic checkEntry(input int addr, input logic [1:0] st, input logic [NN-1:0] sh);
        checkVal($sformatf("entry%0d_state", addr),   dut.uStorage.stateArr[addr],   st);
        checkVal($sformatf("entry%0d_sharers", addr), dut.uStorage.sharersArr[addr], sh);
    endtask

    task automatic waitIdle();
        int cnt = 0;
        while (req_ready !== 1'b1 && cnt < 30) begin
            @(posedge clk); #1;
            cnt++;
        end
        checkVal("req_ready_idle", req_ready, 1);
    endtask

    // One full request; expected behaviour comes from the coherence rules.
    task automatic doReq(input int node, input logic [1:0] rtype, input int addr, input int hold);
        logic [1:0]    st, nst, mtype, rstate;
        logic [NN-1:0] sh, nsh, pm, dest;
        bit            expMsg, expReply, expWb, isRead, isWb, scripted, replied;
        int            order[$];
        int            ackList[$];
        int            pendQ[$];

        st = mState[addr];
        sh = mSharers[addr];
        pm = NN'(1) << node;
        isRead = (rtype == RM);
        isWb = (rtype == WB);
        expMsg = 0; expReply = 0; expWb = 0;
        nst = st; nsh = sh; mtype = 0; dest = 0; rstate = 0;
        if (st == UNC) begin
            if (!isWb) begin
                nst = isRead ? SHR : MOD; nsh = pm; expReply = 1; rstate = nst;
            end
        end else if (st == SHR) begin
            if (isRead) begin
                nsh = sh | pm; expReply = 1; rstate = SHR;
            end else if (!isWb) begin
                dest = sh & ~pm; expMsg = (dest != 0); mtype = M_INV;
                nst = MOD; nsh = pm; expReply = 1; rstate = MOD;
            end
        end else begin
            if (sh == pm) begin
                if (isWb) begin
                    expWb = 1; nst = UNC; nsh = 0;
                end else begin
                    expReply = 1; rstate = MOD;
                end
            end else if (!isWb) begin
                expMsg = 1; dest = sh; expWb = 1; expReply = 1;
                if (isRead) begin
                    mtype = M_FETCH; nst = SHR; nsh = sh | pm; rstate = SHR;
                end else begin
                    mtype = M_FINV; nst = MOD; nsh = pm; rstate = MOD;
                end
            end
        end

        waitIdle();
        req_valid = 1; req_node = NW'(node); req_type = rtype; req_addr = AW'(addr);
        @(posedge clk); #1;
        req_valid = 0;
        checkVal("req_ready_busy", req_ready, 0);
        @(posedge clk); #1;

        if (!expMsg) begin
            checkVal("reply_valid", reply_valid, expReply);
            checkVal("msg_valid_none", msg_valid, 0);
            checkVal("mem_wb", mem_wb, expWb);
            if (expReply) begin
                checkVal("reply_node", reply_node, node);
                checkVal("reply_state", reply_state, rstate);
            end
            @(posedge clk); #1;
            checkVal("req_ready_back", req_ready, 1);
            checkVal("reply_pulse_end", reply_valid, 0);
        end else begin
            checkVal("msg_valid", msg_valid, 1);
            checkVal("msg_type", msg_type, mtype);
            checkVal("msg_dest", msg_dest, dest);
            checkVal("msg_addr", msg_addr, addr);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                checkVal("hold_msg_valid", msg_valid, 1);
                checkVal("hold_msg_dest", msg_dest, dest);
                checkVal("hold_req_ready", req_ready, 0);
            end
            for (int i = 0; i < NN; i++) if (dest[i]) order.push_back(i);
            for (int i = order.size() - 1; i > 0; i--) begin
                int j, t;
                j = $urandom_range(0, i);
                t = order[i]; order[i] = order[j]; order[j] = t;
            end
            scripted = (ackScript.size() != 0);
            msg_ready = 1;
            // An ack on the handshake cycle must be dropped.
            if (!scripted && $urandom_range(0, 1) == 1) begin
                ack_valid = 1; ack_node = NW'(order[0]);
            end
            @(posedge clk); #1;
            msg_ready = 0; ack_valid = 0;
            if (mtype == M_INV || mtype == M_FINV) modelInval += $countones(dest);
            if (mtype == M_FETCH || mtype == M_FINV) modelFetch += 1;
            checkVal("msg_valid_drop", msg_valid, 0);

            if (scripted) begin
                ackList = ackScript;
                ackScript.delete();
            end else begin
                foreach (order[k]) begin
                    if ($urandom_range(0, 3) == 0) ackList.push_back(-1);
                    if ($urandom_range(0, 3) == 0) ackList.push_back($urandom_range(0, NN - 1));
                    ackList.push_back(order[k]);
                end
            end
            pendQ = order;
            replied = 0;
            foreach (ackList[k]) begin
                if (ackList[k] >= 0) begin
                    ack_valid = 1; ack_node = NW'(ackList[k]);
                end
                @(posedge clk); #1;
                ack_valid = 0;
                for (int q = pendQ.size() - 1; q >= 0; q--) begin
                    if (pendQ[q] == ackList[k]) pendQ.delete(q);
                end
                if (pendQ.size() == 0) begin
                    checkVal("reply_valid_ack", reply_valid, 1);
                    checkVal("reply_node_ack", reply_node, node);
                    checkVal("reply_state_ack", reply_state, rstate);
                    checkVal("mem_wb_early", mem_wb, 0);
                    replied = 1;
                    break;
                end else begin
                    checkVal("reply_early", reply_valid, 0);
                end
            end
            @(posedge clk); #1;
            checkVal("mem_wb_msg", mem_wb, expWb);
            checkVal("req_ready_back", req_ready, 1);
            checkVal("reply_pulse_end", reply_valid, 0);
        end
        checkVal("stat_inval", stat_inval, STATS_ON ? modelInval : 0);
        checkVal("stat_fetch", stat_fetch, STATS_ON ? modelFetch : 0);
        mState[addr] = nst;
        mSharers[addr] = nsh;
        $display("txn node=%0d type=%0d addr=%0d msg=%0d dest=%b reply=%0d state=%0d wb=%0d",
                 node, rtype, addr, expMsg, dest, expReply, rstate, expWb);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; req_valid = 0; req_node = 0; req_type = 0; req_addr = 0;
        msg_ready = 0; ack_valid = 0; ack_node = 0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        reset = 0;

        // Simple read of an uncached block.
        doReq(0, RM, 3, 0);
        checkEntry(3, SHR, 4'b0001);

        // Three sharers invalidated, duplicate ack ignored.
        doReq(0, RM, 5, 0);
        doReq(1, RM, 5, 0);
        doReq(2, RM, 5, 0);
        ackScript = '{2, 2, 0, 1};
        doReq(3, WM, 5, 0);
        checkEntry(5, MOD, 4'b1000);

        // Fetch from owner with msg_ready held low for 5 cycles.
        doReq(1, WM, 7, 0);
        doReq(2, RM, 7, 5);
        checkEntry(7, SHR, 4'b0110);

        // Owner write-back, then a stray write-back.
        doReq(3, WM, 7, 0);
        doReq(3, WB, 7, 0);
        checkEntry(7, UNC, 4'b0000);
        doReq(0, WB, 7, 0);
        checkEntry(7, UNC, 4'b0000);

        // Randomized traffic over a few blocks to force conflicts.
        for (int t = 0; t < 80; t++) begin
            doReq($urandom_range(0, NN - 1), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 7), $urandom_range(0, 3));
        end
        for (int b = 0; b < NB; b++) checkEntry(b, mState[b], mSharers[b]);

        // Reset while waiting for the owner's ack.
        doReq(0, WM, 5, 0);
        waitIdle();
        req_valid = 1; req_node = 1; req_type = RM; req_addr = 5;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        checkVal("rst_msg_valid", msg_valid, 1);
        checkVal("rst_msg_dest", msg_dest, 4'b0001);
        msg_ready = 1;
        @(posedge clk); #1;
        msg_ready = 0;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        modelReset();
        checkResetOutputs("midreset");
        checkEntry(5, UNC, 4'b0000);
        ack_valid = 1; ack_node = 0;
        @(posedge clk); #1;
        ack_valid = 0;
        checkVal("post_reset_reply", reply_valid, 0);
        checkVal("post_reset_mem_wb", mem_wb, 0);
        doReq(2, RM, 5, 0);
        checkEntry(5, SHR, 4'b0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
